// File: rtl/svc_dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package svc_dmem_arb_pkg;

   // Requester index: one bit selects between the two ports.
   typedef logic port_idx_t;

   localparam port_idx_t PORT_CPU = 1'b0;
   localparam port_idx_t PORT_DBG = 1'b1;

   // Width of the conflict statistics counter.
   localparam int STAT_W = 16;

endpackage

// File: rtl/svc_rr_arb2.sv
// Two-way arbiter: one-hot grant with round-robin or fixed priority on
// conflict, plus the register remembering the most recent winner.
module svc_rr_arb2
   import svc_dmem_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       fixed_prio,
   output logic [1:0] gnt
);

   port_idx_t last_gnt;

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req[0] && req[1]) begin
            // On conflict the port that did not win last time goes first,
            // unless port 0 is pinned as the permanent winner.
            if (fixed_prio || (last_gnt == PORT_DBG)) begin
               gnt = 2'b01;
            end else begin
               gnt = 2'b10;
            end
         end else begin
            gnt = req;
         end
      end
   end

   // Remember the winner of every grant cycle; reset favours port 0 next.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= PORT_DBG;
      end else if (|gnt) begin
         last_gnt <= gnt[1] ? PORT_DBG : PORT_CPU;
      end
   end

endmodule

// File: rtl/svc_dmem_arb.sv
// Shares the single-port data-memory BRAM between the CPU data port (0)
// and the debug/loader master (1). Drives the BRAM from the winner,
// routes one-cycle-latency read data back to the reader and counts
// conflict cycles in a saturating counter.
module svc_dmem_arb
   import svc_dmem_arb_pkg::*;
#(
   parameter int AW         = 10,
   parameter int DW         = 32,
   parameter int FIXED_PRIO = 0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [AW-1:0]       m0_addr,
   input  logic [DW-1:0]       m0_wdata,
   input  logic [DW/8-1:0]     m0_wstrb,
   output logic                m0_gnt,
   output logic                m0_rvalid,
   output logic [DW-1:0]       m0_rdata,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [AW-1:0]       m1_addr,
   input  logic [DW-1:0]       m1_wdata,
   input  logic [DW/8-1:0]     m1_wstrb,
   output logic                m1_gnt,
   output logic                m1_rvalid,
   output logic [DW-1:0]       m1_rdata,
   output logic                mem_ren,
   output logic [DW/8-1:0]     mem_wen,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata,
   output logic [STAT_W-1:0]   stat_conflicts
);

   localparam int SW = DW / 8;

   logic [1:0]    req;
   logic [1:0]    gnt;
   logic          any_gnt;
   port_idx_t     win;
   logic          sel_we;
   logic [SW-1:0] sel_wstrb;

   logic          rd_vld_p1;
   port_idx_t     rd_owner_p1;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      if (&v) begin
         return v;
      end
      return v + STAT_W'(1);
   endfunction

   assign req = {m1_req, m0_req};

   svc_rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .fixed_prio (FIXED_PRIO != 0),
      .gnt        (gnt)
   );

   assign m0_gnt  = gnt[PORT_CPU];
   assign m1_gnt  = gnt[PORT_DBG];
   assign any_gnt = |gnt;
   // With no grant gnt[1] is low, so the mux falls back to port 0.
   assign win     = gnt[PORT_DBG] ? PORT_DBG : PORT_CPU;

   // Winner mux for the BRAM command; port 0 drives it when idle.
   always_comb begin
      sel_we    = m0_we;
      sel_wstrb = m0_wstrb;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      if (win == PORT_DBG) begin
         sel_we    = m1_we;
         sel_wstrb = m1_wstrb;
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
      end
   end

   assign mem_ren = any_gnt & ~sel_we;
   assign mem_wen = (any_gnt && sel_we) ? sel_wstrb : '0;

   // ---- stage p1: read issued last cycle, data arriving from the BRAM ----
   // Track whether a read was issued last cycle (control, reset-cleared).
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_vld_p1 <= 1'b0;
      end else begin
         rd_vld_p1 <= mem_ren;
      end
   end

   // Track which port issued it; only meaningful when rd_vld_p1 is set.
   always_ff @(posedge clk) begin
      rd_owner_p1 <= win;
   end

   // Gating with rst drops a response whose read was issued just before reset.
   assign m0_rvalid = rd_vld_p1 & ~rst & (rd_owner_p1 == PORT_CPU);
   assign m1_rvalid = rd_vld_p1 & ~rst & (rd_owner_p1 == PORT_DBG);
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

   // Count cycles in which both ports request, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_conflicts <= '0;
      end else if (m0_req && m1_req) begin
         stat_conflicts <= sat_inc(stat_conflicts);
      end
   end

endmodule

// File: tb/tb_svc_dmem_arb.sv
// Directed bench for svc_dmem_arb: a round-robin instance backed by a
// behavioural BRAM and a fixed-priority instance for grant ordering.
module tb_svc_dmem_arb;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Round-robin instance signals
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [9:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_ren;
   logic [3:0]  mem_wen;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [15:0] stat_conflicts;

   // Fixed-priority instance signals
   logic        f_m0_req, f_m1_req;
   logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid;
   logic [31:0] f_m0_rdata, f_m1_rdata;
   logic        f_mem_ren;
   logic [3:0]  f_mem_wen;
   logic [9:0]  f_mem_addr;
   logic [31:0] f_mem_wdata;
   logic [31:0] f_mem_rdata = 32'h0;
   logic [15:0] f_stat;
   logic [9:0]  f_addr  = 10'h000;
   logic [31:0] f_wdata = 32'h0;
   logic [3:0]  f_wstrb = 4'h0;
   logic        f_we    = 1'b0;

   svc_dmem_arb #(.AW(10), .DW(32), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stat_conflicts(stat_conflicts)
   );

   svc_dmem_arb #(.AW(10), .DW(32), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .m0_req(f_m0_req), .m0_we(f_we), .m0_addr(f_addr), .m0_wdata(f_wdata),
      .m0_wstrb(f_wstrb), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
      .m1_req(f_m1_req), .m1_we(f_we), .m1_addr(f_addr), .m1_wdata(f_wdata),
      .m1_wstrb(f_wstrb), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
      .mem_ren(f_mem_ren), .mem_wen(f_mem_wen), .mem_addr(f_mem_addr),
      .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .stat_conflicts(f_stat)
   );

   // Behavioural single-port BRAM with byte enables and one-cycle read latency.
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++) begin
         if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      f_m0_req = 0; f_m1_req = 0;
      cyc(); cyc();
      // Requests during reset must not be granted.
      m0_req = 1; m1_req = 1;
      #1;
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_m1_gnt", m1_gnt, 0);
      check("rst_ren", mem_ren, 0);
      check("rst_wen", mem_wen, 0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      cyc();
      idle();
      rst = 1'b0;
      cyc();
      check("rst_stat", stat_conflicts, 0);

      // Fixed priority: both request three cycles, then m0 drops.
      for (int k = 0; k < 3; k++) begin
         f_m0_req = 1; f_m1_req = 1;
         #1;
         check("fp_m0_gnt", f_m0_gnt, 1);
         check("fp_m1_gnt", f_m1_gnt, 0);
         cyc();
      end
      f_m0_req = 0;
      #1;
      check("fp_m1_gnt_after_drop", f_m1_gnt, 1);
      check("fp_m0_gnt_after_drop", f_m0_gnt, 0);
      cyc();
      f_m1_req = 0;

      // Single requester: m0 write then read back.
      m0_req = 1; m0_we = 1; m0_addr = 10'h010; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
      #1;
      check("wr_m0_gnt", m0_gnt, 1);
      check("wr_wen", mem_wen, 4'hF);
      check("wr_ren", mem_ren, 0);
      cyc();
      m0_we = 0;
      #1;
      check("rd_m0_gnt", m0_gnt, 1);
      check("rd_ren", mem_ren, 1);
      check("wr_no_rvalid", m0_rvalid, 0);
      cyc();
      idle();
      #1;
      check("rd_m0_rvalid", m0_rvalid, 1);
      check("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
      check("rd_m1_rvalid", m1_rvalid, 0);
      cyc();
      check("rd_rvalid_one_cycle", m0_rvalid, 0);

      // Preload via port 1 (leaves port 1 as last winner).
      m1_req = 1; m1_we = 1; m1_wstrb = 4'hF; m1_addr = 10'h001; m1_wdata = 32'h11;
      cyc();
      m1_addr = 10'h002; m1_wdata = 32'h22;
      cyc();
      idle();
      cyc();

      // Round-robin conflict: both read for four cycles.
      for (int k = 0; k < 4; k++) begin
         m0_req = 1; m0_addr = 10'h001;
         m1_req = 1; m1_addr = 10'h002;
         #1;
         check($sformatf("rr_m0_gnt%0d", k), m0_gnt, (k % 2 == 0));
         check($sformatf("rr_m1_gnt%0d", k), m1_gnt, (k % 2 == 1));
         if (k > 0) begin
            // Previous cycle's winner receives its data now.
            check($sformatf("rr_m0_rvalid%0d", k), m0_rvalid, (k % 2 == 1));
            check($sformatf("rr_m1_rvalid%0d", k), m1_rvalid, (k % 2 == 0));
            check($sformatf("rr_rdata%0d", k), mem_rdata, (k % 2 == 1) ? 32'h11 : 32'h22);
         end
         cyc();
      end
      idle();
      #1;
      check("rr_last_m1_rvalid", m1_rvalid, 1);
      check("rr_last_m1_rdata", m1_rdata, 32'h22);
      check("rr_stat", stat_conflicts, 4);
      cyc();

      // Byte strobes.
      m0_req = 1; m0_we = 1; m0_addr = 10'h020; m0_wdata = 32'hAABBCCDD; m0_wstrb = 4'hF;
      cyc();
      idle();
      m1_req = 1; m1_we = 1; m1_addr = 10'h020; m1_wdata = 32'h00000011; m1_wstrb = 4'h1;
      #1;
      check("bs_wen1", mem_wen, 4'h1);
      cyc();
      m1_wdata = 32'hFFFFFFFF; m1_wstrb = 4'h0;
      #1;
      check("bs_zero_gnt", m1_gnt, 1);
      check("bs_zero_wen", mem_wen, 4'h0);
      cyc();
      m1_we = 0;
      cyc();
      idle();
      #1;
      check("bs_m1_rvalid", m1_rvalid, 1);
      check("bs_rdata", m1_rdata, 32'hAABBCC11);
      cyc();

      // Reset mid-read: m1 read granted, then rst the next cycle.
      m1_req = 1; m1_we = 0; m1_addr = 10'h020;
      #1;
      check("mr_m1_gnt", m1_gnt, 1);
      cyc();
      idle();
      rst = 1'b1;
      #1;
      check("mr_rvalid_in_rst", m1_rvalid, 0);
      cyc();
      rst = 1'b0;
      #1;
      check("mr_rvalid_after_rst", m1_rvalid, 0);
      check("mr_stat_cleared", stat_conflicts, 0);
      m0_req = 1; m0_addr = 10'h001; m1_req = 1; m1_addr = 10'h002;
      #1;
      check("mr_first_m0_gnt", m0_gnt, 1);
      check("mr_first_m1_gnt", m1_gnt, 0);
      cyc();
      check("mr_stat_one", stat_conflicts, 1);

      // Saturation: hold both requests long enough to exceed 16 bits.
      for (int k = 0; k < 70000; k++) cyc();
      check("sat_stat", stat_conflicts, 16'hFFFF);
      cyc();
      check("sat_hold", stat_conflicts, 16'hFFFF);
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/svc_dmem_arb.md
Name: svc_dmem_arb

Overview:
Two-requester arbiter that shares the single-port data-memory BRAM of the SoC between the CPU data port (port 0) and a debug/loader master (port 1). It selects one requester per cycle, drives the BRAM port combinationally from the winner, and routes the one-cycle-latency read data back to the requester that issued the read. It also keeps a saturating conflict counter for simulation statistics.

Parameters:
AW, 10, word-address width of the data memory (depth 2**AW words)
DW, 32, data width; must be a multiple of 8
FIXED_PRIO, 0, 0 = round-robin on conflict; 1 = port 0 always wins

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  port 0 access request; held until granted
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  AW  port 0 word address
m0_wdata  in  DW  port 0 write data
m0_wstrb  in  DW/8  port 0 byte enables (writes only)
m0_gnt  out  1  port 0 granted this cycle (combinational)
m0_rvalid  out  1  port 0 read data valid
m0_rdata  out  DW  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1
mem_ren  out  1  BRAM read enable
mem_wen  out  DW/8  BRAM per-byte write enable
mem_addr  out  AW  BRAM address
mem_wdata  out  DW  BRAM write data
mem_rdata  in  DW  BRAM read data, valid one cycle after mem_ren
stat_conflicts  out  16  count of cycles with both req high; saturating

Behaviour:
- Reset (rst high at posedge): last_gnt <= 1, rd_owner_valid <= 0, stat_conflicts <= 0. While rst is high: m0_gnt = m1_gnt = 0, mem_ren = 0, mem_wen = 0, m*_rvalid = 0.
- Grant (combinational): if exactly one req is high, that port is granted. If both are high: FIXED_PRIO=1 grants port 0; otherwise the port != last_gnt is granted. At most one gnt is high per cycle.
- last_gnt register updates to the granted index on every grant cycle and holds otherwise.
- Memory drive: on grant, mem_addr/mem_wdata come from the winner. mem_ren = gnt & ~we. mem_wen = we ? wstrb : 0. When there is no grant, mem_ren = 0, mem_wen = 0, and addr/wdata are don't-care but are driven from port 0 (no X).
- A write with wstrb = 0 is still granted, counts as a grant, and writes nothing.
- Read return: a read granted in cycle N registers rd_owner_valid = 1 and rd_owner = idx. In cycle N+1, m{rd_owner}_rvalid = 1 and m{rd_owner}_rdata = mem_rdata; the other port's rvalid is 0.
- m*_rdata always mirror mem_rdata. Only rvalid qualifies them.
- Back-to-back reads from alternating ports give one rvalid per cycle, each correctly routed. Writes produce no response.
- Requester contract: a requester keeps req, we, addr, wdata and wstrb stable until gnt. The arbiter does not check this.
- Simultaneous events: a read granted in cycle N+1 while the rvalid for cycle N is being returned is legal. The two do not interact.
- Reset mid-operation: a read granted in the cycle before rst rises produces no rvalid (rd_owner_valid is cleared). The first conflict after reset goes to port 0.
- stat_conflicts increments on each cycle with m0_req & m1_req & ~rst. It holds at 16'hFFFF.
- Starvation bound: in round-robin mode, a continuously requesting port is granted within 2 cycles.

Decomposition:
- Package svc_dmem_arb_pkg holds:
  - typedef port_idx_t (1 bit)
  - PORT_CPU = 0, PORT_DBG = 1
  - STAT_W = 16
- Sub-module svc_rr_arb2 contains the 2-way grant logic plus the last_gnt register (inputs: req[1:0], fixed_prio; output: one-hot gnt[1:0]). svc_dmem_arb adds the memory muxing, read-owner pipeline and statistics.

Test Plan:
- Single requester: m0 writes addr 0x010, data 0xDEADBEEF, wstrb 0xF, then reads addr 0x010 -> m0_gnt high in each request cycle; m0_rvalid high exactly 1 cycle after the read grant with m0_rdata 0xDEADBEEF; m1_rvalid stays 0.
- Conflict round-robin (FIXED_PRIO=0): both ports read every cycle for 4 cycles, m0 addr 0x001, m1 addr 0x002, memory preloaded 0x11/0x22 -> grants go 0,1,0,1; rvalid alternates m0 (0x11) / m1 (0x22); stat_conflicts = 4.
- Fixed priority (FIXED_PRIO=1): both request for 3 cycles, then m0 drops -> m0 granted in cycles 1-3, m1 granted in cycle 4.
- Byte strobes: write 0xAABBCCDD with wstrb 0xF, then m1 writes 0x00000011 with wstrb 0x1 to the same address -> read returns 0xAABBCC11. A write with wstrb 0 leaves it unchanged.
- Reset mid-read: m1 read granted, rst asserted the next cycle -> no m1_rvalid. After release, both request -> port 0 granted first; stat_conflicts restarts from 0.
- Saturation: hold both req high for 70000 cycles -> stat_conflicts = 0xFFFF and it does not wrap.
